// File: rtl/nibble_editor_pkg.sv
// Shared types and constants for the nibble editor: FSM states, button indices
// and the digit step helpers used for up/down editing.
package nibble_editor_pkg;

  typedef enum logic {
    EDIT   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_ENTER = 4;
  localparam int NIBBLES   = 8;

  // Digits at or above the radix (only reachable via load) snap to the wrap value.
  function automatic logic [3:0] digit_up(input logic [3:0] d, input int radix);
    if (int'(d) >= radix - 1) return 4'd0;
    return d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_down(input logic [3:0] d, input int radix);
    if (d == 4'd0 || int'(d) >= radix) return 4'(radix - 1);
    return d - 4'd1;
  endfunction

endpackage

// File: rtl/nibble_editor_btn_edge_sync.sv
// Two-flop synchronizer per bit followed by a rising-edge pulse generator.
module btn_edge_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/nibble_editor.sv
// Cursor-based 32-bit digit editor with valid/ready commit of the edited value.
// Optional up/down auto-repeat is built when NIBBLE_EDITOR_AUTOREPEAT_EN is defined.
module nibble_editor
  import nibble_editor_pkg::*;
#(
  parameter int RADIX      = 10,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        commit_ready_i,
  output logic [31:0] data_o,
  output logic [2:0]  sel_o,
  output logic [3:0]  digit_o,
  output logic        commit_valid_o,
  output logic [31:0] commit_data_o
);

  if (RADIX < 2 || RADIX > 16 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
    $error("nibble_editor: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] cdata_q, cdata_d;
  logic [4:0]  btn_lvl, btn_rise, act;
  logic        rpt_up, rpt_dn;

  btn_edge_sync #(.WIDTH(5)) u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_i),
    .level (btn_lvl),
    .rise  (btn_rise)
  );

  // Only the highest-priority edge of the cycle survives.
  always_comb begin
    act = '0;
    if      (btn_rise[BTN_LEFT])  act[BTN_LEFT]  = 1'b1;
    else if (btn_rise[BTN_RIGHT]) act[BTN_RIGHT] = 1'b1;
    else if (btn_rise[BTN_UP])    act[BTN_UP]    = 1'b1;
    else if (btn_rise[BTN_DOWN])  act[BTN_DOWN]  = 1'b1;
    else if (btn_rise[BTN_ENTER]) act[BTN_ENTER] = 1'b1;
  end

`ifdef NIBBLE_EDITOR_AUTOREPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_on_q, rpt_on_d;
  logic        held_up, held_dn;

  assign held_up = (btn_lvl == 5'b00100);
  assign held_dn = (btn_lvl == 5'b01000);

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_on_d  = rpt_on_q;
    rpt_up    = 1'b0;
    rpt_dn    = 1'b0;
    if (state_q != EDIT || load_i || !(held_up || held_dn)) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end else if (btn_rise[BTN_UP] || btn_rise[BTN_DOWN]) begin
      rpt_on_d  = 1'b1;
      rpt_cnt_d = 32'(RPT_DELAY - 1);
    end else if (rpt_on_q) begin
      if (rpt_cnt_q == '0) begin
        rpt_up    = held_up;
        rpt_dn    = held_dn;
        rpt_cnt_d = 32'(RPT_PERIOD - 1);
      end else begin
        rpt_cnt_d = rpt_cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q <= '0;
      rpt_on_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_on_q  <= rpt_on_d;
    end
  end
`else
  logic unused_btn_lvl;
  assign unused_btn_lvl = ^btn_lvl;
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cdata_d = cdata_q;
    case (state_q)
      EDIT: begin
        if (load_i) begin
          data_d = load_data_i;
          sel_d  = '0;
        end else if (act[BTN_LEFT]) begin
          sel_d = sel_q + 3'd1;
        end else if (act[BTN_RIGHT]) begin
          sel_d = sel_q - 3'd1;
        end else if (act[BTN_UP] || rpt_up) begin
          data_d[{sel_q, 2'b00} +: 4] = digit_up(data_q[{sel_q, 2'b00} +: 4], RADIX);
        end else if (act[BTN_DOWN] || rpt_dn) begin
          data_d[{sel_q, 2'b00} +: 4] = digit_down(data_q[{sel_q, 2'b00} +: 4], RADIX);
        end else if (act[BTN_ENTER]) begin
          cdata_d = data_q;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (commit_ready_i) state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EDIT;
      data_q  <= '0;
      sel_q   <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cdata_q <= cdata_d;
    end
  end

  assign data_o         = data_q;
  assign sel_o          = sel_q;
  assign digit_o        = data_q[{sel_q, 2'b00} +: 4];
  assign commit_valid_o = (state_q == COMMIT);
  assign commit_data_o  = cdata_q;

endmodule

// File: tb/tb_nibble_editor.sv
// Scoreboard bench for nibble_editor: stimulus queues expected snapshots and
// commit values, a monitor process pops and compares them against the outputs.
module tb_nibble_editor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn_i = '0;
  logic        load_i = 1'b0;
  logic [31:0] load_data_i = '0;
  logic        commit_ready_i = 1'b0;
  logic [31:0] data_o;
  logic [2:0]  sel_o;
  logic [3:0]  digit_o;
  logic        commit_valid_o;
  logic [31:0] commit_data_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  sel;
    logic        valid;
    logic [31:0] cdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] commit_q[$];

  nibble_editor #(.RADIX(10), .RPT_DELAY(8), .RPT_PERIOD(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_i          (btn_i),
    .load_i         (load_i),
    .load_data_i    (load_data_i),
    .commit_ready_i (commit_ready_i),
    .data_o         (data_o),
    .sel_o          (sel_o),
    .digit_o        (digit_o),
    .commit_valid_o (commit_valid_o),
    .commit_data_o  (commit_data_o)
  );

  always #5 clk = ~clk;

  // Monitor: snapshot checks and commit handshakes, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] want;
    logic [3:0]  want_digit;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      want_digit = e.data[e.sel*4 +: 4];
      total++;
      if (data_o !== e.data || sel_o !== e.sel || digit_o !== want_digit ||
          commit_valid_o !== e.valid || commit_data_o !== e.cdata) begin
        bad++;
        $display("FAIL %s: got data=%h sel=%0d digit=%h valid=%b cdata=%h, want data=%h sel=%0d digit=%h valid=%b cdata=%h",
                 e.name, data_o, sel_o, digit_o, commit_valid_o, commit_data_o,
                 e.data, e.sel, want_digit, e.valid, e.cdata);
      end
    end
    if (!rst && commit_valid_o && commit_ready_i) begin
      total++;
      if (commit_q.size() == 0) begin
        bad++;
        $display("FAIL handshake: got commit_data=%h, want no transfer", commit_data_o);
      end else begin
        want = commit_q.pop_front();
        if (commit_data_o !== want) begin
          bad++;
          $display("FAIL handshake: got commit_data=%h, want %h", commit_data_o, want);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] d, input logic [2:0] s,
                       input logic v, input logic [31:0] cd);
    exp_t e;
    e.name = nm; e.data = d; e.sel = s; e.valid = v; e.cdata = cd;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn_i[b] = 1'b1;
    tick(4);
    btn_i[b] = 1'b0;
    tick(4);
  endtask

  task automatic load(input logic [31:0] v);
    load_i = 1'b1;
    load_data_i = v;
    tick(1);
    load_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset", 32'h0, 3'd0, 1'b0, 32'h0);
    rst = 1'b0;
    tick(2);

    repeat (3) press(0);
    check("left x3", 32'h0, 3'd3, 1'b0, 32'h0);
    repeat (4) press(1);
    check("right wrap", 32'h0, 3'd7, 1'b0, 32'h0);
    press(0);
    check("left wrap", 32'h0, 3'd0, 1'b0, 32'h0);

    load(32'h0000_0009);
    check("load 9", 32'h9, 3'd0, 1'b0, 32'h0);
    press(2);
    check("up wrap", 32'h0, 3'd0, 1'b0, 32'h0);
    press(3);
    check("down wrap", 32'h9, 3'd0, 1'b0, 32'h0);
    load(32'h0000_000F);
    press(2);
    check("up from F", 32'h0, 3'd0, 1'b0, 32'h0);

    btn_i[0] = 1'b1; btn_i[2] = 1'b1;
    tick(4);
    btn_i = '0;
    tick(4);
    check("left beats up", 32'h0, 3'd1, 1'b0, 32'h0);

    btn_i[2] = 1'b1;
    tick(2);
    load_i = 1'b1; load_data_i = 32'h0000_00A7;
    tick(1);
    load_i = 1'b0;
    btn_i = '0;
    tick(5);
    check("load beats up", 32'hA7, 3'd0, 1'b0, 32'h0);
    press(3);
    check("down plain", 32'hA6, 3'd0, 1'b0, 32'h0);
    press(0);
    press(2);
    check("up over radix", 32'h06, 3'd1, 1'b0, 32'h0);
    load(32'h0000_000C);
    press(3);
    check("down over radix", 32'h9, 3'd0, 1'b0, 32'h0);

    load(32'h0000_1230);
    repeat (4) press(2);
    check("edit 1234", 32'h1234, 3'd0, 1'b0, 32'h0);

    commit_q.push_back(32'h0000_1234);
    btn_i[4] = 1'b1;
    tick(2);
    check("enter edge2", 32'h1234, 3'd0, 1'b0, 32'h0);
    tick(1);
    check("enter edge3", 32'h1234, 3'd0, 1'b1, 32'h1234);
    btn_i[4] = 1'b0;
    tick(5);
    press(2);
    load(32'hFFFF_FFFF);
    check("commit hold", 32'h1234, 3'd0, 1'b1, 32'h1234);
    commit_ready_i = 1'b1;
    tick(1);
    commit_ready_i = 1'b0;
    check("commit done", 32'h1234, 3'd0, 1'b0, 32'h1234);

    commit_ready_i = 1'b1;
    tick(2);
    press(3);
    check("down ready in edit", 32'h1233, 3'd0, 1'b0, 32'h1234);
    commit_ready_i = 1'b0;
    commit_q.push_back(32'h0000_1233);
    press(4);
    check("second commit", 32'h1233, 3'd0, 1'b1, 32'h1233);
    commit_ready_i = 1'b1;
    tick(1);
    commit_ready_i = 1'b0;
    check("second done", 32'h1233, 3'd0, 1'b0, 32'h1233);

    load(32'hDEAD_BEEF);
    press(0);
    commit_q.push_back(32'hDEAD_BEEF);
    press(4);
    check("third commit", 32'hDEAD_BEEF, 3'd1, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    total++;
    if (commit_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL async reset: got valid=%b, want 0", commit_valid_o);
    end
    commit_q.delete();
    check("reset in commit", 32'h0, 3'd0, 1'b0, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);

`ifdef NIBBLE_EDITOR_AUTOREPEAT_EN
    btn_i[2] = 1'b1;
    tick(3);
    check("rpt first", 32'h1, 3'd0, 1'b0, 32'h0);
    tick(7);
    check("rpt before delay", 32'h1, 3'd0, 1'b0, 32'h0);
    tick(1);
    check("rpt delay", 32'h2, 3'd0, 1'b0, 32'h0);
    tick(4);
    check("rpt period1", 32'h3, 3'd0, 1'b0, 32'h0);
    tick(4);
    check("rpt period2", 32'h4, 3'd0, 1'b0, 32'h0);
    tick(1);
    btn_i[2] = 1'b0;
    tick(10);
    check("rpt release", 32'h4, 3'd0, 1'b0, 32'h0);
`else
    btn_i[2] = 1'b1;
    tick(30);
    btn_i[2] = 1'b0;
    tick(4);
    check("held up once", 32'h1, 3'd0, 1'b0, 32'h0);
`endif

    total++;
    if (commit_q.size() != 0) begin
      bad++;
      $display("FAIL commit queue: got %0d pending, want 0", commit_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_editor.md
# nibble_editor

Cursor-based 32-bit digit editor for the ATM keypad/display path: left/right buttons move a nibble cursor, up/down change the digit under it, enter hands the finished value to the consumer over a valid/ready handshake. It is the writing counterpart of the nibble-select display reader. It owns the edit buffer that the reader displays, and feeds PIN/amount values to the transaction logic.

## Interface
- `RADIX`, 10: digit modulus; legal range 2..16; 10 = decimal entry.
- `RPT_DELAY`, 50_000_000: cycles up/down must be held before auto-repeat starts.
- `RPT_PERIOD`, 10_000_000: cycles between auto-repeat steps.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_i` in 5: raw buttons. [0] cursor left (sel+1), [1] cursor right (sel-1), [2] up, [3] down, [4] enter.
- `load_i` in 1: preload edit buffer strobe.
- `load_data_i` in 32: preload value.
- `commit_ready_i` in 1: consumer accepts committed value.
- `data_o` out 32: current edit buffer; nibble k is bits [4k+3:4k].
- `sel_o` out 3: cursor nibble index.
- `digit_o` out 4: nibble of `data_o` at `sel_o`, combinational.
- `commit_valid_o` out 1: committed value available.
- `commit_data_o` out 32: committed value, stable while valid.

## Operation
- Each `btn_i` bit passes through a 2-flop synchronizer, then a rising-edge detector. One action per press; a held button does nothing further, except auto-repeat (see Configuration).
- Same-cycle edges use fixed priority [0] > [1] > [2] > [3] > [4]. Only the highest-priority edge acts; the others are discarded.
- Cursor: left: sel = 7 ? 0 : sel+1; right: sel = 0 ? 7 : sel-1.
- Up: d = RADIX-1 ? 0 : d+1. Down: d = 0 ? RADIX-1 : d-1.
- A nibble ≥ RADIX (possible via load) goes to 0 on up and to RADIX-1 on down. Other nibbles are untouched.
- FSM states:
  - EDIT: buttons and load are active. An enter edge sets commit_data_o ← data_o and commit_valid_o ← 1, then moves to COMMIT.
  - COMMIT: all button edges and load_i are ignored. commit_data_o is held. When commit_ready_i is high on a clock edge, commit_valid_o clears on that edge and the FSM returns to EDIT. data_o and sel_o are unchanged by the commit.
- Load (EDIT only): data_o ← load_data_i, sel_o ← 0. It takes precedence over any same-cycle button edge, which is discarded.

## Timing
- Reset values: data_o 0, sel_o 0, digit_o 0, commit_valid_o 0, commit_data_o 0. State is EDIT; synchronizer and edge flops are 0; repeat counter is 0.
- Button latency: the first rising clk edge that samples btn_i high is edge 1. sel_o/data_o update on edge 3; commit_valid_o rises on edge 3 for enter.
- Load latency: 1 cycle; data_o updates on the edge sampling load_i high.
- Handshake: the transfer occurs on the edge where commit_valid_o && commit_ready_i. commit_ready_i high in EDIT has no effect. Earliest next commit is 4 cycles after return to EDIT; it needs a fresh enter edge.
- Reset mid-COMMIT: commit_valid_o drops asynchronously; the pending value is lost.

## Configuration
- `NIBBLE_EDITOR_AUTOREPEAT_EN` defined: while the synchronized up (or down) bit stays high alone, a counter runs. After RPT_DELAY cycles the block issues one extra step, then one every RPT_PERIOD cycles. The counter clears on release, on any other button edge, on load, and in COMMIT. Cursor and enter never repeat.
- Not defined: no repeat counter is synthesized; behaviour is edge-only. RPT_DELAY and RPT_PERIOD are unused.

## Structure
- Package `nibble_editor_pkg` holds:
  - the FSM state enum (EDIT, COMMIT);
  - button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_ENTER=4;
  - the NIBBLES=8 constant.
- One sub-module, `btn_edge_sync`: parameterized width, 2-flop synchronizer plus rising-edge pulse. It has clk/rst and outputs both the synchronized level and the edge pulse.

## Test plan
- Reset, then pulse left 3 times: sel_o = 3. Pulse right 4 times: sel_o = 7 (wrap). Pulse left: sel_o = 0. data_o stays 0.
- Load 0x0000_0009, sel 0, RADIX=10. Up: data_o = 0x0000_0000. Down: 0x0000_0009. Load 0x0000_000F, then up: 0x0000_0000.
- Raise left and up in the same cycle: only sel_o increments; data_o unchanged. Raise load_i together with an up edge: data_o = load_data_i.
- Edit to 0x0000_1234 and press enter: commit_valid_o rises 3 edges after the press, commit_data_o = 0x0000_1234. Hold ready low 5 cycles and press up: no change. Raise ready: valid drops the next edge.
- Assert rst during COMMIT: commit_valid_o goes 0 immediately; all outputs return to reset values.
- With NIBBLE_EDITOR_AUTOREPEAT_EN, RPT_DELAY=8, RPT_PERIOD=4: hold up for 20 synchronized cycles from 0. The digit reaches 1 at the edge, then 2, 3, 4 at the repeat points; after release there are no further steps.
